// File: rtl/hazard_pattern_gen_if.sv
// Pattern generator control/status bundle: pattern request and pause in,
// LED frame, owning mode and step strobe out.
interface hazard_pattern_gen_if #(
  parameter int N_LEDS = 10
);
  logic [1:0]        mode;
  logic              pause;
  logic [N_LEDS-1:0] leds;
  logic [1:0]        active_mode;
  logic              step;

  modport master (output mode, pause, input leds, active_mode, step);
  modport slave  (input mode, pause, output leds, active_mode, step);
endinterface

// File: rtl/hazard_pattern_gen.sv
// N-wide LED bar pattern generator: calm / right sweep / left sweep / bounce,
// stepped by an internal prescaler and freezable with pause.
module hazard_pattern_gen #(
  parameter int N_LEDS   = 10,
  parameter int TICK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_pattern_gen_if.slave  bus
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    M_CALM   = 2'b00,
    M_RIGHT  = 2'b01,
    M_LEFT   = 2'b10,
    M_BOUNCE = 2'b11
  } mode_e;

  // Alternating mask: odd=0 sets bits 0,2,4..., odd=1 sets bits 1,3,5...
  function automatic logic [N_LEDS-1:0] alt_mask(input bit odd);
    logic [N_LEDS-1:0] m;
    for (int i = 0; i < N_LEDS; i++) m[i] = ((i % 2) == (odd ? 1 : 0));
    return m;
  endfunction

  localparam logic [N_LEDS-1:0] EVEN = alt_mask(1'b0);
  localparam logic [N_LEDS-1:0] ODD  = alt_mask(1'b1);
  localparam logic [N_LEDS-1:0] LSB  = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] MSB  = {1'b1, {(N_LEDS-1){1'b0}}};

  function automatic logic [N_LEDS-1:0] start_frame(input mode_e m);
    case (m)
      M_CALM:  return EVEN;
      M_RIGHT: return MSB;
      default: return LSB;  // left sweep and bounce both start at bit 0
    endcase
  endfunction

  logic [CW-1:0]     r_cnt;
  logic [N_LEDS-1:0] r_leds;
  mode_e             r_mode;
  logic              r_up;    // bounce direction: 1 = toward MSB
  logic              r_step;

  logic  w_tick;
  mode_e w_req;

  assign w_tick = (r_cnt == LAST);
  assign w_req  = mode_e'(bus.mode);

  // Prescaler, mode register, frame and direction; everything holds while paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
      r_mode <= M_CALM;
      r_leds <= EVEN;
      r_up   <= 1'b1;
    end else if (bus.pause) begin
      r_step <= 1'b0;
    end else begin
      r_step <= w_tick;
      r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        if (w_req != r_mode) begin
          // New mode shows its start frame first; advancing resumes next step.
          r_mode <= w_req;
          r_leds <= start_frame(w_req);
          r_up   <= 1'b1;
        end else begin
          case (r_mode)
            M_CALM:  r_leds <= (r_leds == EVEN) ? ODD : EVEN;
            M_RIGHT: r_leds <= $onehot(r_leds) ? {r_leds[0], r_leds[N_LEDS-1:1]} : MSB;
            M_LEFT:  r_leds <= $onehot(r_leds) ? {r_leds[N_LEDS-2:0], r_leds[N_LEDS-1]} : LSB;
            default: begin
              if (!$onehot(r_leds)) begin
                r_leds <= LSB;
                r_up   <= 1'b1;
              end else if (r_up) begin
                // Turning at the top moves straight down so the end frame shows once.
                if (r_leds[N_LEDS-1]) begin
                  r_up   <= 1'b0;
                  r_leds <= r_leds >> 1;
                end else begin
                  r_leds <= r_leds << 1;
                end
              end else begin
                if (r_leds[0]) begin
                  r_up   <= 1'b1;
                  r_leds <= r_leds << 1;
                end else begin
                  r_leds <= r_leds >> 1;
                end
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.leds        = r_leds;
  assign bus.active_mode = r_mode;
  assign bus.step        = r_step;
endmodule

// File: doc/hazard_pattern_gen.md
Name: hazard_pattern_gen

Overview:
- Parametrised successor of the 3-LED hazard-light FSM.
- Drives an N-wide LED bar with four selectable patterns (calm, right sweep, left sweep, bounce). An internal prescaler sets the step rate, and a pause input freezes the pattern.
- Sits between the board-level switch/key inputs and LEDR.
- Clocked at the fast board/simulation clock, so no separate divided clock is needed for the pattern rate.

Parameters:
- N_LEDS, 10, LED bar width; legal values >= 2.
- TICK_DIV, 1, clock cycles per pattern step; legal values >= 1. With 1, the pattern steps every enabled cycle.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high; highest priority.
- mode, input, 2, requested pattern: 00 calm, 01 right sweep, 10 left sweep, 11 bounce.
- pause, input, 1, when high, the prescaler and pattern hold.
- leds, output, N_LEDS, current pattern frame (registered).
- active_mode, output, 2, mode the current frame belongs to (registered).
- step, output, 1, one-cycle pulse coincident with each new leds frame.

Behaviour:
- Reset (sampled high at an edge):
  - leds = EVEN mask (bits 0,2,4,... set).
  - active_mode = 00, step = 0.
  - Prescaler count = 0, bounce direction = up.
  - Reset overrides pause and mode.
- Prescaler:
  - Count width is max(1, clog2(TICK_DIV)).
  - If pause = 0: when count == TICK_DIV-1, the count goes to 0 and a step occurs this edge; otherwise the count increments.
  - If pause = 1: the count holds, no step, and leds, active_mode and direction all hold.
- Step = 0 on every non-step edge. Leds and active_mode only change on step edges.
- Mode change on a step edge, when mode != active_mode:
  - active_mode <= mode.
  - leds <= start frame of the new mode; no advance that step.
  - Bounce direction <= up.
  - Mode changes between steps take effect only at the next step. The last value sampled at the step edge wins.
- Start frames:
  - Calm = EVEN mask.
  - Right = MSB only (bit N-1).
  - Left = LSB only (bit 0).
  - Bounce = LSB only.
- Advance on a step edge, when mode == active_mode:
  - Calm: toggle between EVEN mask and ODD mask (bits 1,3,...).
    - Any frame that is neither mask → EVEN.
    - N=3 gives 101 ↔ 010.
  - Right: logical shift toward LSB. Bit 0 wraps to bit N-1.
  - Left: shift toward MSB. Bit N-1 wraps to bit 0.
  - Bounce:
    - Single dot moves up (toward MSB) or down per the direction register.
    - At bit N-1 while up: direction flips to down, and this step moves to N-2.
    - At bit 0 while down: direction flips to up, and this step moves to 1.
    - Each end frame is shown for exactly one step. N=4 sequence: 0001,0010,0100,1000,0100,0010,0001,0010,...
    - N=2 bounce alternates 01,10.
  - Sweep/bounce modes: if leds is not one-hot (defensive case), load the mode's start frame.
- State machine: one state register for the mode, plus the frame register and the direction bit.
  - Every reachable frame in the sweep and bounce modes has exactly one bit set.
  - In calm mode, frames alternate between the EVEN and ODD masks.
- Latency:
  - The first step after reset occurs at the TICK_DIV-th unpaused edge after reset is released.
- Pause asserted on the same edge a step would occur: no step. The count stays at TICK_DIV-1, so a step occurs on the first unpaused edge.

Test Plan:
- N_LEDS=3, TICK_DIV=1: reset, then mode=00 for 4 cycles → leds 010,101,010,101, with step=1 each cycle.
- N_LEDS=4, TICK_DIV=1: mode=01 from reset → first step loads 1000 with active_mode=01, then 0100,0010,0001,1000 (wrap). Mode=10 from reset → 0001,0010,0100,1000,0001.
- N_LEDS=4, TICK_DIV=1, mode=11 → 0001,0010,0100,1000,0100,0010,0001,0010; no end frame repeats.
- N_LEDS=10, TICK_DIV=3, mode=00 → step pulses on cycles 3,6,9 after reset; leds holds between steps; first new frame = ODD mask 1010101010.
- TICK_DIV=3, sweep running, pause=1 for 5 cycles mid-count → leds, step and count frozen; on release, the remaining count completes before the next step.
- Mode 01 at leds=0010, switch to 11 between steps, assert reset mid-bounce → next step gives 0001 with direction up; reset edge gives leds=0101 (N=4), active_mode=00, step=0.
